// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the five-stage pipeline.
//
// Resolves branches, performs word loads/stores against a local data memory
// whose access takes WAIT_CYCLES extra cycles (upstream is stalled meanwhile),
// and registers results into the MEM/WB output registers.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned memory ops are rejected (no stall, no write,
//               wb_RegWrite forced 0, one-cycle align_err pulse)
//   undefined : alu_result[1:0] ignored, align_err tied 0
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   MemToReg/RegWrite/MemRead/
//   MemWrite/Branch                 control from EX/MEM
//   branch_target, zero             branch destination, ALU zero flag
//   alu_result, rt_data, write_reg  address/result, store data, destination
//   pc_src, pc_branch_target        branch decision (combinational)
//   stall                           freeze upstream pipeline (combinational)
//   wb_*                            registered MEM/WB outputs
//   align_err                       registered misalignment pulse
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic [31:0] branch_target,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rt_data,
    input  logic [4:0]  write_reg,
    output logic        pc_src,
    output logic [31:0] pc_branch_target,
    output logic        stall,
    output logic        wb_MemToReg,
    output logic        wb_RegWrite,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg,
    output logic        align_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              mem_op;
    logic              misaligned;
    logic              reject;
    logic              complete;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       mem [DEPTH];
    logic              unused_addr_bits;

    assign mem_op = MemRead | MemWrite;
    // Word index wraps modulo DEPTH; upper address bits are dropped.
    assign idx    = alu_result[ADDR_W+1:2];
    assign unused_addr_bits = ^{alu_result[31:ADDR_W+2], alu_result[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & (alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Inputs are held stable while stalled, so a misaligned op can only be
    // seen in IDLE; it never enters BUSY.
    assign reject = (state == IDLE) & misaligned;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    complete = 1'b0;
                end else if (mem_op && (WAIT_CYCLES > 0)) begin
                    stall     = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_INIT;
                end else begin
                    complete = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != 8'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pc_src           = Branch & zero & ~stall;
    assign pc_branch_target = branch_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            wb_MemToReg   <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_read_data  <= 32'd0;
            wb_alu_result <= 32'd0;
            wb_write_reg  <= 5'd0;
            align_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            align_err <= reject;
            if (complete || reject) begin
                wb_MemToReg   <= MemToReg;
                wb_RegWrite   <= RegWrite & ~reject;
                wb_alu_result <= alu_result;
                wb_write_reg  <= write_reg;
                // Read sees the pre-write word when MemRead and MemWrite coincide.
                if (MemRead && !reject)
                    wb_read_data <= mem[idx];
            end else begin
                // Bubble: kill control, hold data fields.
                wb_MemToReg <= 1'b0;
                wb_RegWrite <= 1'b0;
            end
        end
    end

    // Memory contents are never reset; a reset aborts any pending store.
    always_ff @(posedge clk) begin
        if (!reset && complete && MemWrite)
            mem[idx] <= rt_data;
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemToReg, RegWrite, MemRead, MemWrite, Branch, zero;
    logic [31:0] branch_target, alu_result, rt_data;
    logic [4:0]  write_reg;
    logic        pc_src, stall, wb_MemToReg, wb_RegWrite, align_err;
    logic [31:0] pc_branch_target, wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;

    int checks = 0;
    int failures = 0;

    // Reference model: word memory plus the last value expected on wb_read_data.
    logic [31:0] mdl [256];
    logic [31:0] exp_rd;
    logic [31:0] written [$];

    mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .branch_target(branch_target),
        .zero(zero), .alu_result(alu_result), .rt_data(rt_data),
        .write_reg(write_reg), .pc_src(pc_src), .pc_branch_target(pc_branch_target),
        .stall(stall), .wb_MemToReg(wb_MemToReg), .wb_RegWrite(wb_RegWrite),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
        .wb_write_reg(wb_write_reg), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_bad(input logic mem, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return mem && (a[1:0] != 2'b00);
`else
        return 1'b0 & mem & a[0];
`endif
    endfunction

    task automatic idle_inputs();
        MemToReg = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        Branch = 0; zero = 0; branch_target = 0; alu_result = 0;
        rt_data = 0; write_reg = 0;
    endtask

    // One instruction through the stage: drive, count stall cycles, check
    // bubbles, then check MEM/WB against the model.
    task automatic op(input logic mr, input logic mw, input logic rw, input logic m2r,
                      input logic br, input logic z, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] wreg);
        logic        bad;
        int          n;
        int          exp_stalls;
        logic [7:0]  wi;
        @(negedge clk);
        MemRead = mr; MemWrite = mw; RegWrite = rw; MemToReg = m2r;
        Branch = br; zero = z; branch_target = 32'h100 + addr;
        alu_result = addr; rt_data = data; write_reg = wreg;
        bad = is_bad(mr | mw, addr);
        exp_stalls = ((mr | mw) && !bad) ? WAIT : 0;
        wi = addr[9:2];
        #1;
        chk("pc_src", {31'd0, pc_src}, {31'd0, br & z & (exp_stalls == 0)});
        chk("pc_branch_target", pc_branch_target, 32'h100 + addr);
        n = 0;
        while (stall && n < 20) begin
            @(posedge clk); #1;
            chk("bubble_regwrite", {31'd0, wb_RegWrite}, 32'd0);
            chk("bubble_memtoreg", {31'd0, wb_MemToReg}, 32'd0);
            n++;
        end
        chk("stall_cycles", n, exp_stalls);
        @(posedge clk); #1;
        if (mr && !bad) exp_rd = mdl[wi];
        if (mw && !bad) mdl[wi] = data;
        chk("wb_regwrite", {31'd0, wb_RegWrite}, {31'd0, rw & ~bad});
        chk("wb_memtoreg", {31'd0, wb_MemToReg}, {31'd0, m2r});
        chk("wb_alu_result", wb_alu_result, addr);
        chk("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, wreg});
        chk("wb_read_data", wb_read_data, exp_rd);
        chk("align_err", {31'd0, align_err}, {31'd0, bad});
    endtask

    initial begin
        logic [31:0] a, d;
        idle_inputs();
        exp_rd = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_regwrite", {31'd0, wb_RegWrite}, 32'd0);
        chk("rst_wb_memtoreg", {31'd0, wb_MemToReg}, 32'd0);
        chk("rst_wb_read_data", wb_read_data, 32'd0);
        chk("rst_wb_alu_result", wb_alu_result, 32'd0);
        chk("rst_wb_write_reg", {27'd0, wb_write_reg}, 32'd0);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Pass-through add.
        op(0, 0, 1, 0, 0, 0, 32'h1234, 32'h0, 5'd5);
        // Store then load with wait states.
        op(0, 1, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        op(1, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd7);
        // Branch taken / not taken; branch suppressed while stalled.
        op(0, 0, 0, 0, 1, 1, 32'h40, 32'h0, 5'd0);
        op(0, 0, 0, 0, 1, 0, 32'h40, 32'h0, 5'd0);
        op(1, 0, 1, 1, 1, 1, 32'h10, 32'h0, 5'd3);

        // Reset arriving on what would be the completing edge of a store.
        @(negedge clk);
        MemWrite = 1; alu_result = 32'h10; rt_data = 32'h5;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("busy_rst_regwrite", {31'd0, wb_RegWrite}, 32'd0);
        chk("busy_rst_read_data", wb_read_data, 32'd0);
        chk("busy_rst_alu_result", wb_alu_result, 32'd0);
        chk("busy_rst_write_reg", {27'd0, wb_write_reg}, 32'd0);
        idle_inputs();
        #1;
        chk("busy_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); reset = 1'b0;
        exp_rd = 32'd0;
        op(1, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd9);

        // Address wrap: byte 0x400 aliases word 0.
        op(0, 1, 0, 0, 0, 0, 32'h400, 32'hA5, 5'd0);
        op(1, 0, 1, 1, 0, 0, 32'h0, 32'h0, 5'd1);
        // Read and write together: load sees the old word.
        op(1, 1, 1, 1, 0, 0, 32'h0, 32'h77, 5'd2);
        op(1, 0, 1, 1, 0, 0, 32'h400, 32'h0, 5'd2);

`ifdef MEM_ALIGN_CHECK_EN
        op(0, 1, 0, 0, 0, 0, 32'h13, 32'h12345678, 5'd0);
        op(1, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd4);
`endif

        written.push_back(32'h10);
        written.push_back(32'h0);
        // Randomized mix of pass-through, stores and loads of written words.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: op(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom, 32'h0, 5'($urandom));
                1: begin
                    a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0, 8'($urandom), 2'b00};
                    d = $urandom;
                    op(0, 1, 0, 0, 0, 0, a, d, 5'd0);
                    written.push_back(a);
                end
                default: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    a[31:10] = 22'($urandom);
                    op(1, 0, 1, 1, 1'($urandom), 1'($urandom), a, 32'h0, 5'($urandom));
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM register and feeding the write-back stage. It resolves branches, performs word loads/stores to a local data memory with a configurable access latency (stalling upstream while busy), and registers results into integrated MEM/WB output registers.

## Interface
- `DEPTH`, 256: data memory depth in 32-bit words (power of two).
- `ADDR_W`, 8: word-index width, log2(DEPTH).
- `WAIT_CYCLES`, 2: extra cycles per memory access; 0 = single-cycle access.

- `clk` in 1: clock; one clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `MemToReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch` in 1 each: control from EX/MEM.
- `branch_target` in 32: branch destination PC.
- `zero` in 1: ALU zero flag.
- `alu_result` in 32: byte address, or pass-through result.
- `rt_data` in 32: store data.
- `write_reg` in 5: destination register.
- `pc_src` out 1: take branch; combinational.
- `pc_branch_target` out 32: equals `branch_target`; combinational.
- `stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM; combinational.
- `wb_MemToReg`, `wb_RegWrite` out 1 each: registered control to WB.
- `wb_read_data` out 32: registered load data.
- `wb_alu_result` out 32: registered ALU result.
- `wb_write_reg` out 5: registered destination.
- `align_err` out 1: registered misalignment pulse (0 when feature compiled out).

## Operation
- `mem_op` = `MemRead | MemWrite`. Word index = `alu_result[ADDR_W+1:2]`; upper bits ignored (wraps modulo DEPTH).
- FSM states IDLE, BUSY; 8-bit down-counter `cnt`.
- IDLE, no `mem_op` (or `WAIT_CYCLES`=0): `stall`=0; at edge MEM/WB loads inputs; load data = mem[index] if `MemRead`; store performed if `MemWrite`.
- IDLE, `mem_op`, `WAIT_CYCLES`>0: `stall`=1; next state BUSY, `cnt`<=`WAIT_CYCLES`-1; MEM/WB loads a bubble (`wb_RegWrite`=0, `wb_MemToReg`=0, data fields hold prior values).
- BUSY, `cnt`≠0: `stall`=1, `cnt` decrements, bubble into MEM/WB.
- BUSY, `cnt`=0: `stall`=0; access completes at this edge (store written / load captured, MEM/WB loads inputs); next state IDLE.
- Upstream holds all inputs stable while `stall`=1; inputs sampled only on completing cycle.
- `pc_src` = `Branch & zero & ~stall`.
- `MemRead` and `MemWrite` both high: store performed, `wb_read_data` gets the pre-write word.
- Memory contents are not reset; uninitialised reads are X.

## Timing
- Reset: state IDLE, `cnt`=0, all `wb_*` outputs 0, `align_err`=0; `stall`=0 after reset.
- Non-memory op: 1-cycle latency to `wb_*`.
- Memory op: occupies `WAIT_CYCLES`+1 cycles; `stall` high for exactly `WAIT_CYCLES` cycles; `wb_*` valid the cycle after completion.
- Back-to-back memory ops: each pays full latency; completing cycle returns to IDLE, next op enters BUSY the following cycle.
- Reset during BUSY: access aborted, no memory write, outputs to reset values next edge.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: a `mem_op` with `alu_result[1:0]`≠0 is rejected in IDLE — no stall, no memory write, `wb_RegWrite` forced 0, `align_err`=1 for one cycle.
- Undefined: `alu_result[1:0]` ignored (access to word containing address); `align_err` tied 0.

## Test plan
- Reset then add pass-through (`RegWrite`=1, `alu_result`=0x1234, `write_reg`=5) -> next cycle `wb_alu_result`=0x1234, `wb_write_reg`=5, `stall` never high.
- Store 0xDEADBEEF to 0x10 with `WAIT_CYCLES`=2 -> `stall` high 2 cycles, bubbles (`wb_RegWrite`=0); later load from 0x10 -> `wb_read_data`=0xDEADBEEF after 3-cycle occupancy.
- `Branch`=1, `zero`=1, `branch_target`=0x40 -> `pc_src`=1 same cycle, `pc_branch_target`=0x40; `zero`=0 -> `pc_src`=0.
- Store to 0x10, assert `reset` in BUSY with different data 0x5 -> load from 0x10 returns prior contents, all `wb_*`=0 after reset.
- Address wrap: store 0xA5 at byte 0x400 (DEPTH=256) -> load from 0x0 returns 0xA5.
- With `MEM_ALIGN_CHECK_EN`: store to 0x13 -> `align_err` one-cycle pulse, no stall, memory word at 0x10 unchanged.
